// File: rtl/pixel_stream_pkg.sv
// ============================================================================
// pixel_stream_pkg : shared types and constants for the pixel stream generator
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package pixel_stream_pkg;

    localparam int PIXEL_W        = 8;
    localparam int CNT_W          = 8;
    localparam int DEF_IMG_WIDTH  = 112;
    localparam int DEF_IMG_HEIGHT = 112;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SOF    = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HBLANK = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ============================================================================
// raster_counter : column/row counters plus a running raster read address
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_counter
    import pixel_stream_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int ADDR_W     = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              clear,
    output logic [CNT_W-1:0]  col,
    output logic [CNT_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_pix
);

    localparam logic [CNT_W-1:0] C_LAST_COL = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] C_LAST_ROW = CNT_W'(IMG_HEIGHT - 1);

    logic [CNT_W-1:0]  r_col;
    logic [CNT_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;
    logic              w_last_col;

    assign w_last_col = (r_col == C_LAST_COL);

    // Address advances by one per read, so it tracks row*IMG_WIDTH+col without a multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (clear) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (step) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + CNT_W'(1);
            end else begin
                r_col <= r_col + CNT_W'(1);
            end
        end
    end

    assign col      = r_col;
    assign row      = r_row;
    assign addr     = r_addr;
    assign last_col = w_last_col;
    assign last_pix = w_last_col && (r_row == C_LAST_ROW);

endmodule

`default_nettype wire

// File: rtl/pixel_stream_gen.sv
// ============================================================================
// pixel_stream_gen : streams one raster frame from a sync-read RAM with h-blank
// Optional test pattern via macro PIXEL_GEN_PATTERN_EN.  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_stream_gen
    import pixel_stream_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int H_BLANK    = 4,
    parameter int ADDR_W     = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pattern_en,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIXEL_W-1:0] rd_data,
    output logic               frame_start,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               pixel_valid_out,
    output logic               busy,
    output logic               done
);

    localparam logic [15:0] C_BLANK_LAST = (H_BLANK > 0) ? 16'(H_BLANK - 1) : 16'd0;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_cnt;
    logic                w_rd_en;
    logic                w_step;
    logic                w_clear;
    logic [CNT_W-1:0]    w_col;
    logic [CNT_W-1:0]    w_row;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_last_col;
    logic                w_last_pix;
    logic [ADDR_W-1:0]   r_addr_hold;
    logic                r_v1;
    logic                r_valid;
    logic [PIXEL_W-1:0]  r_pix;
    logic [PIXEL_W-1:0]  w_pix_src;

    raster_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .ADDR_W     (ADDR_W)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .step     (w_step),
        .clear    (w_clear),
        .col      (w_col),
        .row      (w_row),
        .addr     (w_addr),
        .last_col (w_last_col),
        .last_pix (w_last_pix)
    );

    // r_cnt restarts on every state change; it times HBLANK and DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_SOF;
            ST_SOF:    w_next = ST_ACTIVE;
            ST_ACTIVE: begin
                if (w_last_col) begin
                    if (w_last_pix)      w_next = ST_DRAIN;
                    else if (H_BLANK > 0) w_next = ST_HBLANK;
                end
            end
            ST_HBLANK: if (r_cnt == C_BLANK_LAST) w_next = ST_ACTIVE;
            ST_DRAIN:  if (r_cnt == 16'd1) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en     = 1'b0;
        w_step      = 1'b0;
        w_clear     = 1'b0;
        frame_start = 1'b0;
        done        = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_SOF: begin
                frame_start = 1'b1;
                w_clear     = 1'b1;
            end
            ST_ACTIVE: begin
                w_rd_en = 1'b1;
                w_step  = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef PIXEL_GEN_PATTERN_EN
    logic               r_pat_mode;
    logic [PIXEL_W-1:0] r_pat_d1;

    // Pattern choice is frozen at start; the pattern value rides alongside the RAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat_mode <= 1'b0;
            r_pat_d1   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) r_pat_mode <= pattern_en;
            if (w_rd_en) r_pat_d1 <= w_row + w_col;
        end
    end

    assign w_pix_src = r_pat_mode ? r_pat_d1 : rd_data;
`else
    logic w_unused_inputs;
    assign w_unused_inputs = ^{pattern_en, w_col, w_row};
    assign w_pix_src       = rd_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_hold <= '0;
            r_v1        <= 1'b0;
            r_valid     <= 1'b0;
            r_pix       <= '0;
        end else begin
            if (w_rd_en) r_addr_hold <= w_addr;
            r_v1    <= w_rd_en;
            r_valid <= r_v1;
            if (r_v1) r_pix <= w_pix_src;
        end
    end

    assign rd_en           = w_rd_en;
    assign rd_addr         = w_rd_en ? w_addr : r_addr_hold;
    assign pixel_out       = r_pix;
    assign pixel_valid_out = r_valid;

endmodule

`default_nettype wire
